reg_file_write_port: RTL and testbench
======================================

// Module: reg_file_write_port
// PURPOSE
//  Write side of the 4 x 32-bit register bank; its q0..q3 outputs feed the read-select mux.
//  Buffers write requests in a small in-order FIFO under a valid/ready handshake.
//  Commits one entry per cycle into the bank, with byte-enable merge.
//  Exposes a per-register pending mask so control logic can detect read-after-write hazards.
// PARAMETERS
//  WIDTH  32  data width of each register; must be a multiple of 8
//  DEPTH  2   write-buffer entries; 2 or 4
// PORTS
//  clk           in   1              rising-edge clock
//  rst_n         in   1              asynchronous, active-low reset
//  wr_valid      in   1              write request present
//  wr_ready      out  1              buffer can accept a request
//  wr_addr       in   2              target register, 0..3
//  wr_data       in   WIDTH          write data
//  wr_be         in   WIDTH/8        byte enables; bit k controls data[8k+7:8k]
//  hold          in   1              1 = stall commits; buffer keeps filling
//  q0,q1,q2,q3   out  WIDTH          register contents (registered outputs)
//  pending       out  4              bit i = 1 when any buffered entry targets register i
//  count         out  $clog2(DEPTH+1) number of buffered entries
//  commit_valid  out  1              pulses 1 cycle after each commit edge
//  commit_addr   out  2              register written by that commit
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - q0..q3=0, buffer empty, count=0, pending=0, commit_valid=0, commit_addr=0.
//    - wr_ready=1 once rst_n is released.
//    - Assertion mid-operation discards all buffered entries immediately.
//  - Handshake:
//    - A request is accepted on a rising edge where wr_valid & wr_ready.
//    - wr_ready = (count != DEPTH), decoded from registered count.
//    - When full, wr_ready stays 0 even if a commit occurs on the same edge (no same-cycle pass-through).
//    - wr_addr, wr_data and wr_be are sampled only on acceptance.
//  - Commit:
//    - On each edge with !hold & count!=0, the head entry is popped.
//    - For each k with be[k]=1: q[addr][8k+7:8k] <= data[8k+7:8k]; other bytes are unchanged.
//    - Bypass: none. Accepted at edge N -> earliest visible on q at edge N+1. Latency = 1 + cycles held.
//    - Entries commit strictly in acceptance order. Two writes to the same register merge bytes in order.
//    - wr_be=0: the entry is still popped and commit_valid still pulses; q is unchanged.
//  - Simultaneous accept and commit: count is unchanged; FIFO pointers wrap modulo DEPTH.
//  - pending:
//    - Combinational OR over valid entries of the one-hot decode of each entry's addr.
//    - Reflects the state after the last edge.
//  - commit_valid and commit_addr are registered. commit_valid=0 on any edge without a commit.
//  - Counters and pointers are sized so that overflow cannot occur. Push when full and pop when empty are impossible by construction.
// TESTING
//  1. Reset, then write addr=2, data=0xDEADBEEF, be=0xF.
//     -> q2=0xDEADBEEF one edge after acceptance; commit_valid=1, commit_addr=2; pending=0.
//  2. q1=0x11223344, then write be=0x5, data=0xAABBCCDD.
//     -> q1=0x11BB33DD; q0, q2, q3 unchanged.
//  3. hold=1, two writes (DEPTH=2).
//     -> count=2, wr_ready=0, pending=0b1010 for addrs 1 and 3.
//     -> Release hold: commits occur over 2 edges in order; count returns to 0 and wr_ready returns to 1.
//  4. Full buffer with wr_valid held high and hold dropped.
//     -> No accept on the first commit edge; accept on the following edge; no entry lost or duplicated.
//  5. Back-to-back writes to addr=0 with be=0x3 then be=0xC.
//     -> q0 holds the low half from the first write and the high half from the second, applied in order.
//  6. Assert rst_n=0 with 2 entries buffered and q3=0x5A5A5A5A.
//     -> All outputs 0 asynchronously; after release, no stale commit occurs.

Source files
------------

// File: rtl/reg_file_write_port_if.sv
// Write-request handshake bundle for the 4-entry register bank write port.
// The requester drives valid/addr/data/byte-enables; the write port answers with ready.
interface reg_file_write_port_if #(
  parameter int WIDTH = 32
);
  logic               wr_valid;
  logic               wr_ready;
  logic [1:0]         wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH/8-1:0] wr_be;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_be,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_be,
    output wr_ready
  );
endinterface

// File: rtl/reg_file_write_port.sv
// Write side of the 4 x WIDTH register bank.
// Requests are queued in a DEPTH-entry in-order buffer and committed one per cycle
// with a byte-enable merge. The pending mask exposes which registers still have
// queued writes so readers can detect read-after-write hazards.
module reg_file_write_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  reg_file_write_port_if.slave       wr,
  input  logic                       hold,
  output logic [WIDTH-1:0]           q0,
  output logic [WIDTH-1:0]           q1,
  output logic [WIDTH-1:0]           q2,
  output logic [WIDTH-1:0]           q3,
  output logic [3:0]                 pending,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       commit_valid,
  output logic [1:0]                 commit_addr
);

  localparam int BW = WIDTH / 8;
  // DEPTH is restricted to 2 or 4, so pointers wrap naturally at their width.
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Buffer storage
  logic [1:0]       entryAddr_r  [DEPTH];
  logic [WIDTH-1:0] entryData_r  [DEPTH];
  logic [BW-1:0]    entryBe_r    [DEPTH];
  logic [DEPTH-1:0] entryValid_r;
  logic [PW-1:0]    headPtr_r;
  logic [PW-1:0]    tailPtr_r;
  logic [CW-1:0]    count_r;

  // Register bank and commit report
  logic [WIDTH-1:0] qBank_r [4];
  logic             commitValid_r;
  logic [1:0]       commitAddr_r;

  logic             pushS;
  logic             popS;
  logic             readyS;
  logic [3:0]       pendingS;

  // Byte-enable merge: enabled lanes take the new data, the rest keep the old value.
  function automatic logic [WIDTH-1:0] mergeBytes(
    input logic [WIDTH-1:0] oldVal,
    input logic [WIDTH-1:0] newVal,
    input logic [BW-1:0]    be
  );
    logic [WIDTH-1:0] res;
    res = oldVal;
    for (int k = 0; k < BW; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = newVal[8*k +: 8];
      end else begin
        res[8*k +: 8] = oldVal[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Ready comes only from the registered count, so a full buffer never accepts
  // on the same edge that frees a slot.
  assign readyS      = (count_r != CW'(DEPTH));
  assign wr.wr_ready = readyS;
  assign pushS       = wr.wr_valid & readyS;
  assign popS        = ~hold & (count_r != {CW{1'b0}});

  // Buffer pointers, occupancy and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr_r    <= {PW{1'b0}};
      tailPtr_r    <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      entryValid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entryAddr_r[i] <= 2'b00;
        entryData_r[i] <= {WIDTH{1'b0}};
        entryBe_r[i]   <= {BW{1'b0}};
      end
    end else begin
      if (pushS) begin
        entryAddr_r[tailPtr_r]  <= wr.wr_addr;
        entryData_r[tailPtr_r]  <= wr.wr_data;
        entryBe_r[tailPtr_r]    <= wr.wr_be;
        entryValid_r[tailPtr_r] <= 1'b1;
        tailPtr_r               <= tailPtr_r + PW'(1);
      end else begin
        tailPtr_r <= tailPtr_r;
      end
      // Push and pop never address the same slot: push needs a free slot,
      // pop needs an occupied one, so the head differs from the tail here.
      if (popS) begin
        entryValid_r[headPtr_r] <= 1'b0;
        headPtr_r               <= headPtr_r + PW'(1);
      end else begin
        headPtr_r <= headPtr_r;
      end
      case ({pushS, popS})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Commit the head entry into the bank and report which register it touched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        qBank_r[r] <= {WIDTH{1'b0}};
      end
      commitValid_r <= 1'b0;
      commitAddr_r  <= 2'b00;
    end else begin
      commitValid_r <= popS;
      if (popS) begin
        qBank_r[entryAddr_r[headPtr_r]] <= mergeBytes(qBank_r[entryAddr_r[headPtr_r]],
                                                      entryData_r[headPtr_r],
                                                      entryBe_r[headPtr_r]);
        commitAddr_r <= entryAddr_r[headPtr_r];
      end else begin
        commitAddr_r <= commitAddr_r;
      end
    end
  end

  // Pending mask: OR of the one-hot target of every occupied buffer slot.
  always_comb begin
    pendingS = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      pendingS = pendingS | (entryValid_r[i] ? (4'b0001 << entryAddr_r[i]) : 4'b0000);
    end
  end

  assign q0           = qBank_r[0];
  assign q1           = qBank_r[1];
  assign q2           = qBank_r[2];
  assign q3           = qBank_r[3];
  assign pending      = pendingS;
  assign count        = count_r;
  assign commit_valid = commitValid_r;
  assign commit_addr  = commitAddr_r;

endmodule

// File: tb/tb_reg_file_write_port.sv
// Testbench for reg_file_write_port: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the write buffer and bank.
module tb_reg_file_write_port;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    logic [3:0]  b;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [31:0] q0, q1, q2, q3;
  logic [3:0]  pending;
  logic [1:0]  count;
  logic        commit_valid;
  logic [1:0]  commit_addr;
  logic [31:0] qArr [4];

  reg_file_write_port_if #(.WIDTH(WIDTH)) wrIf ();

  reg_file_write_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wrIf),
    .hold         (hold),
    .q0           (q0),
    .q1           (q1),
    .q2           (q2),
    .q3           (q3),
    .pending      (pending),
    .count        (count),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr)
  );

  assign qArr[0] = q0;
  assign qArr[1] = q1;
  assign qArr[2] = q2;
  assign qArr[3] = q3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  entry_t      mq [$];
  logic [31:0] mReg [4];
  logic        mCv;
  logic [1:0]  mCa;
  int          numChecks = 0;
  int          numErrors = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numErrors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelMerge(input logic [31:0] oldVal, input logic [31:0] newVal,
                                             input logic [3:0] be);
    logic [31:0] res;
    res = oldVal;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = newVal[8*k +: 8];
    end
    return res;
  endfunction

  function automatic logic [3:0] modelPending();
    logic [3:0] p;
    p = 4'b0000;
    foreach (mq[i]) p[mq[i].a] = 1'b1;
    return p;
  endfunction

  task automatic modelReset();
    mq.delete();
    for (int r = 0; r < 4; r++) mReg[r] = 32'h0;
    mCv = 1'b0;
    mCa = 2'd0;
  endtask

  task automatic checkAll(input string tag);
    for (int r = 0; r < 4; r++) checkVal($sformatf("%s_q%0d", tag, r), {32'h0, qArr[r]}, {32'h0, mReg[r]});
    checkVal({tag, "_count"}, {62'h0, count}, 64'(mq.size()));
    checkVal({tag, "_pending"}, {60'h0, pending}, {60'h0, modelPending()});
    checkVal({tag, "_ready"}, {63'h0, wrIf.wr_ready}, {63'h0, (mq.size() != DEPTH)});
    checkVal({tag, "_cvalid"}, {63'h0, commit_valid}, {63'h0, mCv});
    if (mCv) checkVal({tag, "_caddr"}, {62'h0, commit_addr}, {62'h0, mCa});
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model across the
  // rising edge, then check everything at the next falling edge.
  task automatic doCycle(input logic v, input logic [1:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic h, input string tag);
    entry_t e;
    logic   acc;
    logic   com;
    wrIf.wr_valid = v;
    wrIf.wr_addr  = a;
    wrIf.wr_data  = d;
    wrIf.wr_be    = b;
    hold          = h;
    acc = v && (mq.size() != DEPTH);
    com = !h && (mq.size() != 0);
    @(posedge clk);
    if (com) begin
      e = mq.pop_front();
      mReg[e.a] = modelMerge(mReg[e.a], e.d, e.b);
      mCv = 1'b1;
      mCa = e.a;
    end else begin
      mCv = 1'b0;
    end
    if (acc) begin
      e.a = a;
      e.d = d;
      e.b = b;
      mq.push_back(e);
    end
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic idle(input logic h, input string tag);
    doCycle(1'b0, 2'd0, 32'h0, 4'h0, h, tag);
  endtask

  initial begin
    rst_n         = 1'b0;
    hold          = 1'b0;
    wrIf.wr_valid = 1'b0;
    wrIf.wr_addr  = 2'd0;
    wrIf.wr_data  = 32'h0;
    wrIf.wr_be    = 4'h0;
    modelReset();
    repeat (3) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkAll("post_reset");

    // Full-word write, visible one edge after acceptance
    doCycle(1'b1, 2'd2, 32'hDEADBEEF, 4'hF, 1'b0, "t1_acc");
    checkVal("t1_pending_before", {60'h0, pending}, 64'h4);
    idle(1'b0, "t1_commit");
    checkVal("t1_q2", {32'h0, q2}, 64'hDEADBEEF);
    checkVal("t1_caddr", {62'h0, commit_addr}, 64'h2);

    // Partial byte-enable merge
    doCycle(1'b1, 2'd1, 32'h11223344, 4'hF, 1'b0, "t2_full");
    doCycle(1'b1, 2'd1, 32'hAABBCCDD, 4'h5, 1'b0, "t2_part");
    idle(1'b0, "t2_commit");
    checkVal("t2_q1", {32'h0, q1}, 64'h11BB33DD);
    checkVal("t2_q2", {32'h0, q2}, 64'hDEADBEEF);

    // Hold fills the buffer; release drains it in order
    doCycle(1'b1, 2'd1, 32'h01010101, 4'hF, 1'b1, "t3_w1");
    doCycle(1'b1, 2'd3, 32'h03030303, 4'hF, 1'b1, "t3_w3");
    checkVal("t3_count", {62'h0, count}, 64'h2);
    checkVal("t3_ready", {63'h0, wrIf.wr_ready}, 64'h0);
    checkVal("t3_pending", {60'h0, pending}, 64'hA);
    idle(1'b0, "t3_c1");
    checkVal("t3_first_addr", {62'h0, commit_addr}, 64'h1);
    idle(1'b0, "t3_c2");
    checkVal("t3_second_addr", {62'h0, commit_addr}, 64'h3);
    checkVal("t3_ready_back", {63'h0, wrIf.wr_ready}, 64'h1);

    // Full buffer, valid held: no accept on first commit edge, accept on the next
    doCycle(1'b1, 2'd0, 32'h0A0A0A0A, 4'hF, 1'b1, "t4_f1");
    doCycle(1'b1, 2'd2, 32'h0C0C0C0C, 4'hF, 1'b1, "t4_f2");
    doCycle(1'b1, 2'd1, 32'h77777777, 4'hF, 1'b0, "t4_noacc");
    checkVal("t4_count_noacc", {62'h0, count}, 64'h1);
    doCycle(1'b1, 2'd1, 32'h77777777, 4'hF, 1'b0, "t4_acc");
    checkVal("t4_count_acc", {62'h0, count}, 64'h1);
    idle(1'b0, "t4_d1");
    idle(1'b0, "t4_d2");
    checkVal("t4_q1", {32'h0, q1}, 64'h77777777);
    checkVal("t4_q2", {32'h0, q2}, 64'h0C0C0C0C);

    // Back-to-back half-word writes to the same register
    doCycle(1'b1, 2'd0, 32'h11112222, 4'h3, 1'b0, "t5_lo");
    doCycle(1'b1, 2'd0, 32'h33334444, 4'hC, 1'b0, "t5_hi");
    idle(1'b0, "t5_d");
    checkVal("t5_q0", {32'h0, q0}, 64'h33332222);

    // Zero byte-enable still pops and pulses commit_valid
    doCycle(1'b1, 2'd0, 32'hFFFFFFFF, 4'h0, 1'b0, "t5b_be0");
    idle(1'b0, "t5b_d");
    checkVal("t5b_q0", {32'h0, q0}, 64'h33332222);

    // Asynchronous reset with entries buffered
    doCycle(1'b1, 2'd3, 32'h5A5A5A5A, 4'hF, 1'b0, "t6_q3");
    idle(1'b0, "t6_c");
    doCycle(1'b1, 2'd0, 32'h99999999, 4'hF, 1'b1, "t6_b1");
    doCycle(1'b1, 2'd1, 32'h88888888, 4'hF, 1'b1, "t6_b2");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkVal("t6_q3_rst", {32'h0, q3}, 64'h0);
    checkVal("t6_q0_rst", {32'h0, q0}, 64'h0);
    checkVal("t6_count_rst", {62'h0, count}, 64'h0);
    checkVal("t6_pending_rst", {60'h0, pending}, 64'h0);
    checkVal("t6_cvalid_rst", {63'h0, commit_valid}, 64'h0);
    wrIf.wr_valid = 1'b0;
    hold          = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      idle(1'b0, "t6_after");
      checkVal("t6_no_stale", {63'h0, commit_valid}, 64'h0);
    end

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      doCycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 32'($urandom()),
              4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), "rnd");
    end
    repeat (3) idle(1'b0, "drain");

    $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
    $finish;
  end

endmodule
